// File: rtl/hilo_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_mult_ctrl
//  Purpose  : Controls an external unsigned 32x32 multiplier on behalf of the
//             EX stage for the MULT/MULTU/MADD/MADDU/MSUB/MSUBU family.
//             Signed operands are reduced to magnitudes before issue and the
//             sign is re-applied to the 64-bit product afterwards. The result
//             is optionally accumulated into the forwarded HI/LO value and
//             written back with a one-cycle strobe.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   clock, all state on rising edge
//    rst            in   1   asynchronous reset, active low
//    op_valid_i     in   1   multiply-family op present in EX
//    op_i           in   3   000 MULT 001 MULTU 010 MADD 011 MADDU
//                            100 MSUB 101 MSUBU (110/111 ignored)
//    src_a_i        in  32   operand A
//    src_b_i        in  32   operand B
//    hi_i, lo_i     in  32   current (forwarded) HI/LO
//    flush_i        in   1   pipeline flush, abandons any op in flight
//    mult_mcand_o   out 32   multiplicand to the unsigned multiplier
//    mult_mplier_o  out 32   multiplier to the unsigned multiplier
//    mult_start_o   out  1   one-cycle start pulse
//    mult_flush_o   out  1   flush forwarded to the multiplier
//    mult_result_i  in  64   unsigned product
//    mult_ready_i   in   1   one-cycle product-valid pulse
//    stall_o        out  1   hold EX while an op is in flight
//    hilo_we_o      out  1   HI/LO write strobe
//    hi_o, lo_o     out 32   HI/LO write data (held between writes)
// ============================================================================
module hilo_mult_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush_i,
  output logic [31:0] mult_mcand_o,
  output logic [31:0] mult_mplier_o,
  output logic        mult_start_o,
  output logic        mult_flush_o,
  input  logic [63:0] mult_result_i,
  input  logic        mult_ready_i,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_FIX   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // op_i[2:1] selects how the product is combined with HI/LO;
  // op_i[0] selects unsigned (1) versus signed (0) operands.
  localparam logic [1:0] KIND_MUL  = 2'b00;
  localparam logic [1:0] KIND_MADD = 2'b01;
  localparam logic [1:0] KIND_MSUB = 2'b10;

  localparam logic [2:0] OP_LAST_VALID = 3'b101;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]  state_q,   state_d;
  logic [1:0]  kind_q,    kind_d;
  logic        neg_q,     neg_d;
  logic [31:0] mcand_q,   mcand_d;
  logic [31:0] mplier_q,  mplier_d;
  logic [63:0] acc_q,     acc_d;
  logic [63:0] prod_q,    prod_d;
  logic [63:0] res_q,     res_d;
  logic [31:0] hi_last_q, hi_last_d;
  logic [31:0] lo_last_q, lo_last_d;

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  logic        op_legal;
  logic        accept;
  logic        op_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] prod_signed;
  logic [63:0] fix_result;

  always_comb begin
    op_legal  = (op_i <= OP_LAST_VALID);
    accept    = (state_q == ST_IDLE) && op_valid_i && !flush_i && op_legal;
    op_signed = ~op_i[0];

    // Two's-complement negate of 32'h8000_0000 yields 32'h8000_0000, which is
    // exactly the magnitude 2^31 when read as unsigned, so no special case.
    abs_a = (op_signed && src_a_i[31]) ? (~src_a_i + 32'd1) : src_a_i;
    abs_b = (op_signed && src_b_i[31]) ? (~src_b_i + 32'd1) : src_b_i;

    prod_signed = neg_q ? (~prod_q + 64'd1) : prod_q;

    case (kind_q)
      KIND_MADD: fix_result = acc_q + prod_signed;
      KIND_MSUB: fix_result = acc_q - prod_signed;
      default:   fix_result = prod_signed;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    res_d     = res_q;
    hi_last_d = hi_last_q;
    lo_last_d = lo_last_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_ISSUE;
          kind_d   = op_i[2:1];
          mcand_d  = abs_a;
          mplier_d = abs_b;
          neg_d    = op_signed & (src_a_i[31] ^ src_b_i[31]);
          acc_d    = {hi_i, lo_i};
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mult_ready_i) begin
          prod_d  = mult_result_i;
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        res_d   = fix_result;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        hi_last_d = res_q[63:32];
        lo_last_d = res_q[31:0];
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush overrides everything: back to IDLE, and a result sitting in
    // DONE is not committed to the held HI/LO copy.
    if (flush_i) begin
      state_d   = ST_IDLE;
      hi_last_d = hi_last_q;
      lo_last_d = lo_last_q;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      kind_q    <= 2'b00;
      neg_q     <= 1'b0;
      mcand_q   <= 32'd0;
      mplier_q  <= 32'd0;
      acc_q     <= 64'd0;
      prod_q    <= 64'd0;
      res_q     <= 64'd0;
      hi_last_q <= 32'd0;
      lo_last_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      res_q     <= res_d;
      hi_last_q <= hi_last_d;
      lo_last_q <= lo_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mult_mcand_o  = mcand_q;
  assign mult_mplier_o = mplier_q;
  assign mult_flush_o  = flush_i;
  assign mult_start_o  = (state_q == ST_ISSUE) && !flush_i;

  // accept already excludes flush_i.
  assign stall_o = accept ||
                   (!flush_i && ((state_q == ST_ISSUE) ||
                                 (state_q == ST_WAIT)  ||
                                 (state_q == ST_FIX)));

  assign hilo_we_o = (state_q == ST_DONE) && !flush_i;

  // During the write cycle present the fresh result; otherwise hold the last
  // value actually written.
  assign hi_o = hilo_we_o ? res_q[63:32] : hi_last_q;
  assign lo_o = hilo_we_o ? res_q[31:0]  : lo_last_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_mult_ctrl
//  Purpose  : Self-checking bench for hilo_mult_ctrl with a fixed-latency
//             unsigned multiplier model and a scoreboard of HI/LO writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_mult_ctrl;

  localparam int N_LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] src_a_i = 32'd0;
  logic [31:0] src_b_i = 32'd0;
  logic [31:0] hi_i = 32'd0;
  logic [31:0] lo_i = 32'd0;
  logic        flush_i = 1'b0;
  logic [31:0] mult_mcand_o;
  logic [31:0] mult_mplier_o;
  logic        mult_start_o;
  logic        mult_flush_o;
  logic [63:0] mult_result_i;
  logic        mult_ready_i;
  logic        stall_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  always #5 clk = ~clk;

  hilo_mult_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid_i    (op_valid_i),
    .op_i          (op_i),
    .src_a_i       (src_a_i),
    .src_b_i       (src_b_i),
    .hi_i          (hi_i),
    .lo_i          (lo_i),
    .flush_i       (flush_i),
    .mult_mcand_o  (mult_mcand_o),
    .mult_mplier_o (mult_mplier_o),
    .mult_start_o  (mult_start_o),
    .mult_flush_o  (mult_flush_o),
    .mult_result_i (mult_result_i),
    .mult_ready_i  (mult_ready_i),
    .stall_o       (stall_o),
    .hilo_we_o     (hilo_we_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  // --------------------------------------------------------------------------
  // Multiplier model: product ready N_LAT edges after the start is sampled.
  // stray_req injects an unsolicited ready pulse.
  // --------------------------------------------------------------------------
  logic [2:0]  m_cnt;
  logic [63:0] m_prod;
  logic        stray_req = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt         <= 3'd0;
      m_prod        <= 64'd0;
      mult_ready_i  <= 1'b0;
      mult_result_i <= 64'd0;
    end else begin
      mult_ready_i <= 1'b0;
      if (mult_flush_o) begin
        m_cnt <= 3'd0;
      end else if (mult_start_o) begin
        m_cnt  <= 3'(N_LAT);
        m_prod <= {32'd0, mult_mcand_o} * {32'd0, mult_mplier_o};
      end else if (m_cnt != 3'd0) begin
        m_cnt <= m_cnt - 3'd1;
        if (m_cnt == 3'd1) begin
          mult_ready_i  <= 1'b1;
          mult_result_i <= m_prod;
        end
      end
      if (stray_req) begin
        mult_ready_i  <= 1'b1;
        mult_result_i <= 64'hDEAD_BEEF_0BAD_F00D;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] sb[$];
  logic [63:0] last_exp = 64'd0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_hilo(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
    logic [63:0] p;
    logic [63:0] r;
    if (!op[0]) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    else        p = {32'd0, a} * {32'd0, b};
    case (op[2:1])
      2'b01:   r = {hi, lo} + p;
      2'b10:   r = {hi, lo} - p;
      default: r = p;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mag(input logic [2:0] op, input logic [31:0] x);
    return (!op[0] && x[31]) ? (32'd0 - x) : x;
  endfunction

  // Scoreboard consumer: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && hilo_we_o) begin
      if (sb.size() == 0) check_val("spurious_we", 64'd1, 64'd0);
      else check_val("hilo_write", {hi_o, lo_o}, sb.pop_front());
    end
  end

  // Drive one op in the accept cycle; returns at the negedge in ISSUE.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
    @(negedge clk);
    op_valid_i = 1'b1;
    op_i       = op;
    src_a_i    = a;
    src_b_i    = b;
    hi_i       = hi;
    lo_i       = lo;
    #1;
    check_val("accept_stall", 64'(stall_o), 64'd1);
    last_exp = ref_hilo(op, a, b, hi, lo);
    sb.push_back(last_exp);
    @(negedge clk);
    op_valid_i = 1'b0;
    op_i       = 3'd0;
    check_val("start_pulse", 64'(mult_start_o), 64'd1);
    check_val("mcand", 64'(mult_mcand_o), 64'(mag(op, a)));
    check_val("mplier", 64'(mult_mplier_o), 64'(mag(op, b)));
  endtask

  // Wait for the write strobe, checking latency, stall and the single start.
  task automatic finish_op();
    int k = 0;
    int stall_lo = 0;
    int starts = 0;
    int mc_chg = 0;
    logic [31:0] mc0;
    mc0 = mult_mcand_o;
    while (!hilo_we_o && k < 40) begin
      if (!stall_o) stall_lo++;
      if (k > 0 && mult_start_o) starts++;
      if (mult_mcand_o !== mc0) mc_chg++;
      @(negedge clk);
      k++;
    end
    check_val("latency", 64'(k), 64'(3 + N_LAT));
    check_val("stall_busy_low", 64'(stall_lo), 64'd0);
    check_val("extra_start", 64'(starts), 64'd0);
    check_val("mcand_stable", 64'(mc_chg), 64'd0);
    check_val("stall_done", 64'(stall_o), 64'd0);
    @(negedge clk);
    check_val("we_one_cycle", 64'(hilo_we_o), 64'd0);
    check_val("hold_hilo", {hi_o, lo_o}, last_exp);
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!mult_ready_i && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check_val(tag, 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_stall", 64'(stall_o), 64'd0);
    check_val("rst_we", 64'(hilo_we_o), 64'd0);
    check_val("rst_start", 64'(mult_start_o), 64'd0);
    check_val("rst_mcand", {mult_mcand_o, mult_mplier_o}, 64'd0);
    check_val("rst_hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b1;

    // Directed ops
    launch(3'b001, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
    finish_op();
    check_val("multu_value", last_exp, 64'h0000_0001_FFFF_FFFE);
    launch(3'b000, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0);
    finish_op();
    check_val("mult_min_value", last_exp, 64'h4000_0000_0000_0000);
    launch(3'b000, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0);
    finish_op();
    launch(3'b010, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
    finish_op();
    launch(3'b101, 32'd1, 32'd1, 32'd0, 32'd0);
    finish_op();
    launch(3'b100, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd10);
    finish_op();
    launch(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op();

    // Random ops
    for (int i = 0; i < 6; i++) begin
      launch(3'($urandom_range(0, 5)), $urandom, $urandom, $urandom, $urandom);
      finish_op();
    end

    // Flush coincident with ready in WAIT
    launch(3'b001, 32'd3, 32'd3, 32'd0, 32'd0);
    wait_ready("flush_ready_timeout");
    flush_i = 1'b1;
    #1;
    check_val("flush_fwd", 64'(mult_flush_o), 64'd1);
    check_val("flush_stall", 64'(stall_o), 64'd0);
    check_val("flush_we", 64'(hilo_we_o), 64'd0);
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check_val("post_flush_stall", 64'(stall_o), 64'd0);
    check_val("post_flush_start", 64'(mult_start_o), 64'd0);
    repeat (10) @(negedge clk);
    launch(3'b000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'd0, 32'd0);
    finish_op();

    // Unsolicited ready in IDLE
    @(negedge clk);
    stray_req = 1'b1;
    @(negedge clk);
    stray_req = 1'b0;
    repeat (3) @(negedge clk);
    check_val("stray_ready_stall", 64'(stall_o), 64'd0);

    // Reserved opcode
    @(negedge clk);
    op_valid_i = 1'b1;
    op_i       = 3'b110;
    #1;
    check_val("op110_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    check_val("op110_start", 64'(mult_start_o), 64'd0);
    check_val("op110_stall_next", 64'(stall_o), 64'd0);
    op_i = 3'b111;
    @(negedge clk);
    check_val("op111_start", 64'(mult_start_o), 64'd0);
    op_valid_i = 1'b0;
    op_i       = 3'd0;
    repeat (5) @(negedge clk);

    // Reset asserted in FIX
    launch(3'b000, 32'd9, 32'hFFFF_FFFE, 32'd0, 32'd0);
    wait_ready("rst_ready_timeout");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rstfix_stall", 64'(stall_o), 64'd0);
    check_val("rstfix_we", 64'(hilo_we_o), 64'd0);
    check_val("rstfix_start", 64'(mult_start_o), 64'd0);
    check_val("rstfix_mcand", {mult_mcand_o, mult_mplier_o}, 64'd0);
    check_val("rstfix_hilo", {hi_o, lo_o}, 64'd0);
    if (sb.size() != 0) void'(sb.pop_front());
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Normal op after reset
    launch(3'b011, 32'd6, 32'd7, 32'd0, 32'd100);
    finish_op();

    repeat (5) @(negedge clk);
    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
